fifo_wr_adapter: RTL and testbench

//  Parametrised write-side adapter for the async FIFO, in the clk_w domain. Takes a valid/ready

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_wr_skid_buf.sv | 58 +++++
 rtl/fifo_wr_adapter.sv | 82 ++++++++
 tb/tb_fifo_wr_adapter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write side: drop-filter modes and a
// constant-foldable log2 used to size pointers and occupancy.
package fifo_pkg;

  localparam int DROP_NONE     = 0;
  localparam int DROP_ZERO     = 1;
  localparam int DROP_ZERO_OVF = 2;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_skid_buf.sv
// DEPTH-entry flop-based elastic buffer with wrapping read/write pointers and
// an occupancy count. The owner guarantees push only when not full and pop only when not empty.
module fifo_wr_skid_buf
  import fifo_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk_w,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_w or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level==0 masks stale contents on head_data.
  always_ff @(posedge clk_w) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;

endmodule

// File: rtl/fifo_wr_adapter.sv
// Write-side adapter for the async FIFO: valid/ready intake with zero-word
// filtering, elastic buffering against overflow stalls, and saturating debug counters.
module fifo_wr_adapter
  import fifo_pkg::*;
#(
  parameter  int DW        = 8,
  parameter  int DEPTH     = 4,
  parameter  int DROP_MODE = 2,
  parameter  int CNT_W     = 16,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic             clk_w,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             overflow,
  output logic             wr_en,
  output logic [DW-1:0]    data_w,
  output logic [AW:0]      level,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic             accept;
  logic             drop;
  logic             store;
  logic             stall;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // in_ready and wr_en depend only on registered occupancy plus overflow gating of the drain.
  assign in_ready = (level != FULL_LEVEL);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && (in_data == '0) &&
                    ((DROP_MODE == DROP_ZERO) || ((DROP_MODE == DROP_ZERO_OVF) && overflow));
  assign store    = accept && !drop;
  assign wr_en    = (level != '0) && !overflow;
  assign stall    = (level != '0) && overflow;

  fifo_wr_skid_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_w     (clk_w),
    .reset_n   (reset_n),
    .push      (store),
    .push_data (in_data),
    .pop       (wr_en),
    .head_data (data_w),
    .level     (level)
  );

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      drop_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (drop && (drop_cnt_q != '1))   drop_cnt_d  = drop_cnt_q + 1'b1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_w or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Bench for fifo_wr_adapter: three instances (zero-drop-on-overflow, drop-all-zero,
// 4-bit counters) share stimulus; a negedge scoreboard checks every FIFO write.
module tb_fifo_wr_adapter;

  logic       clk_w = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       overflow;
  logic       cnt_clr;

  logic        in_ready_a, wr_en_a;
  logic [7:0]  data_w_a;
  logic [2:0]  level_a;
  logic [15:0] drop_cnt_a, stall_cnt_a;

  logic        in_ready_b, wr_en_b;
  logic [7:0]  data_w_b;
  logic [2:0]  level_b;
  logic [15:0] drop_cnt_b, stall_cnt_b;

  logic        in_ready_c, wr_en_c;
  logic [7:0]  data_w_c;
  logic [2:0]  level_c;
  logic [3:0]  drop_cnt_c, stall_cnt_c;

  always #5 clk_w = ~clk_w;

  fifo_wr_adapter #(.DW(8), .DEPTH(4), .DROP_MODE(2), .CNT_W(16)) u_dut_a (
    .clk_w(clk_w), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .overflow(overflow), .wr_en(wr_en_a), .data_w(data_w_a),
    .level(level_a), .cnt_clr(cnt_clr), .drop_cnt(drop_cnt_a), .stall_cnt(stall_cnt_a)
  );

  fifo_wr_adapter #(.DW(8), .DEPTH(4), .DROP_MODE(1), .CNT_W(16)) u_dut_b (
    .clk_w(clk_w), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .overflow(overflow), .wr_en(wr_en_b), .data_w(data_w_b),
    .level(level_b), .cnt_clr(cnt_clr), .drop_cnt(drop_cnt_b), .stall_cnt(stall_cnt_b)
  );

  fifo_wr_adapter #(.DW(8), .DEPTH(4), .DROP_MODE(0), .CNT_W(4)) u_dut_c (
    .clk_w(clk_w), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .overflow(overflow), .wr_en(wr_en_c), .data_w(data_w_c),
    .level(level_c), .cnt_clr(cnt_clr), .drop_cnt(drop_cnt_c), .stall_cnt(stall_cnt_c)
  );

  // Instance under observation: 0 = DROP_MODE 2, 1 = DROP_MODE 1, 2 = DROP_MODE 0 with CNT_W 4.
  int          sel = 0;
  logic        obs_in_ready, obs_wr_en;
  logic [7:0]  obs_data_w;
  logic [2:0]  obs_level;
  logic [15:0] obs_drop_cnt, obs_stall_cnt;

  always_comb begin
    obs_in_ready  = in_ready_a;
    obs_wr_en     = wr_en_a;
    obs_data_w    = data_w_a;
    obs_level     = level_a;
    obs_drop_cnt  = drop_cnt_a;
    obs_stall_cnt = stall_cnt_a;
    if (sel == 1) begin
      obs_in_ready  = in_ready_b;
      obs_wr_en     = wr_en_b;
      obs_data_w    = data_w_b;
      obs_level     = level_b;
      obs_drop_cnt  = drop_cnt_b;
      obs_stall_cnt = stall_cnt_b;
    end else if (sel == 2) begin
      obs_in_ready  = in_ready_c;
      obs_wr_en     = wr_en_c;
      obs_data_w    = data_w_c;
      obs_level     = level_c;
      obs_drop_cnt  = {12'd0, drop_cnt_c};
      obs_stall_cnt = {12'd0, stall_cnt_c};
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         wr_seen;
  int         max_level;
  bit         ready_low_seen;

  function automatic bit model_drop(input int s, input logic [7:0] d, input logic ovf);
    if (d != 8'h00) return 1'b0;
    if (s == 1)     return 1'b1;
    if (s == 0)     return ovf;
    return 1'b0;
  endfunction

  // Scoreboard: pop on every write, then push what the next edge will store.
  always @(negedge clk_w) begin
    if (mon_en) begin
      if (obs_wr_en) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got data_w=%02h, expected no write", obs_data_w);
        end else begin
          logic [7:0] exp_d;
          exp_d = exp_q.pop_front();
          if (obs_data_w !== exp_d) begin
            errors++;
            $display("FAIL sb_data_w: got %02h expected %02h", obs_data_w, exp_d);
          end
        end
      end
      if (int'(obs_level) > max_level) max_level = int'(obs_level);
      if (!obs_in_ready) ready_low_seen = 1'b1;
      if (in_valid && obs_in_ready && !model_drop(sel, in_data, overflow))
        exp_q.push_back(in_data);
    end
  end

  task automatic clear_stats();
    wr_seen        = 0;
    max_level      = 0;
    ready_low_seen = 1'b0;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    overflow = 1'b0;
    cnt_clr  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_w);
    @(negedge clk_w);
    reset_n = 1'b1;
    @(posedge clk_w);
    #1;
    clear_stats();
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_w);
    #1;
  endtask

  // Holds in_valid until the word is taken; returns just after the accepting edge.
  task automatic push_word(input logic [7:0] d);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_w);
      acc = obs_in_ready;
      @(posedge clk_w);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %02h not accepted within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    @(negedge clk_w);
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", obs_in_ready); end
    checks++; if (obs_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", obs_wr_en); end
    checks++; if (obs_data_w !== 8'h00) begin errors++; $display("FAIL reset_data_w: got %02h expected 00", obs_data_w); end
    checks++; if (obs_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", obs_level); end
    checks++; if (obs_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", obs_drop_cnt); end
    checks++; if (obs_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", obs_stall_cnt); end
    @(posedge clk_w);
    #1;
  endtask

  task automatic test_basic_flow();
    sel = 0;
    do_reset();
    push_word(8'h11);
    checks++;
    if (obs_wr_en !== 1'b1 || obs_data_w !== 8'h11) begin
      errors++;
      $display("FAIL basic_latency: got wr_en=%b data_w=%02h expected wr_en=1 data_w=11", obs_wr_en, obs_data_w);
    end
    push_word(8'h22);
    push_word(8'h33);
    idle(4);
    checks++; if (wr_seen !== 3) begin errors++; $display("FAIL basic_write_count: got %0d expected 3", wr_seen); end
    checks++; if (max_level > 1) begin errors++; $display("FAIL basic_max_level: got %0d expected <=1", max_level); end
    checks++; if (ready_low_seen) begin errors++; $display("FAIL basic_in_ready: got low at least once expected always 1"); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stall_fill();
    bit acc;
    bit done;
    sel = 0;
    do_reset();
    overflow = 1'b1;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    push_word(8'hA4);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk_w);
    checks++; if (obs_level !== 3'd4) begin errors++; $display("FAIL stall_level: got %0d expected 4", obs_level); end
    checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", obs_in_ready); end
    checks++; if (obs_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en: got %b expected 0", obs_wr_en); end
    checks++; if (obs_stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt_start: got %0d expected 3", obs_stall_cnt); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_w);
      #1;
      @(negedge clk_w);
      checks++;
      if (obs_stall_cnt !== 16'(3 + k)) begin
        errors++;
        $display("FAIL stall_cnt_step: got %0d expected %0d", obs_stall_cnt, 3 + k);
      end
    end
    @(posedge clk_w);
    #1;
    overflow = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_w);
      acc = obs_in_ready;
      @(posedge clk_w);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL stall_a5_accept: got not accepted expected accepted after release"); end
    idle(8);
    checks++; if (wr_seen !== 5) begin errors++; $display("FAIL stall_write_count: got %0d expected 5", wr_seen); end
    checks++; if (obs_stall_cnt !== 16'd7) begin errors++; $display("FAIL stall_cnt_final: got %0d expected 7", obs_stall_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stall_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_drop_on_overflow();
    sel = 0;
    do_reset();
    overflow = 1'b1;
    push_word(8'h00);
    checks++; if (obs_drop_cnt !== 16'd1) begin errors++; $display("FAIL dropovf_cnt: got %0d expected 1", obs_drop_cnt); end
    checks++; if (obs_level !== 3'd0) begin errors++; $display("FAIL dropovf_level: got %0d expected 0", obs_level); end
    overflow = 1'b0;
    push_word(8'h00);
    push_word(8'h07);
    idle(4);
    checks++; if (obs_drop_cnt !== 16'd1) begin errors++; $display("FAIL dropovf_cnt_after: got %0d expected 1", obs_drop_cnt); end
    checks++; if (wr_seen !== 2) begin errors++; $display("FAIL dropovf_write_count: got %0d expected 2", wr_seen); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL dropovf_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_drop_all();
    sel = 1;
    do_reset();
    overflow = 1'b1;
    push_word(8'h00);
    push_word(8'h05);
    push_word(8'h00);
    push_word(8'h06);
    checks++; if (obs_level !== 3'd2) begin errors++; $display("FAIL dropall_level: got %0d expected 2", obs_level); end
    checks++; if (obs_drop_cnt !== 16'd2) begin errors++; $display("FAIL dropall_cnt: got %0d expected 2", obs_drop_cnt); end
    overflow = 1'b0;
    @(negedge clk_w);
    checks++; if (obs_wr_en !== 1'b1) begin errors++; $display("FAIL dropall_first_write: got wr_en=%b expected 1", obs_wr_en); end
    @(negedge clk_w);
    checks++; if (obs_wr_en !== 1'b1) begin errors++; $display("FAIL dropall_no_bubble: got wr_en=%b expected 1", obs_wr_en); end
    @(posedge clk_w);
    #1;
    idle(3);
    checks++; if (wr_seen !== 2) begin errors++; $display("FAIL dropall_write_count: got %0d expected 2", wr_seen); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL dropall_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    sel = 2;
    do_reset();
    overflow = 1'b1;
    push_word(8'h3C);
    idle(20);
    checks++; if (obs_stall_cnt !== 16'd15) begin errors++; $display("FAIL sat_stall_cnt: got %0d expected 15", obs_stall_cnt); end
    cnt_clr = 1'b1;
    @(posedge clk_w);
    #1;
    cnt_clr = 1'b0;
    checks++; if (obs_stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_clear: got %0d expected 0", obs_stall_cnt); end
    idle(1);
    checks++; if (obs_stall_cnt !== 16'd1) begin errors++; $display("FAIL sat_resume: got %0d expected 1", obs_stall_cnt); end
    overflow = 1'b0;
    idle(4);
    checks++; if (wr_seen !== 1) begin errors++; $display("FAIL sat_write_count: got %0d expected 1", wr_seen); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sat_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    sel = 0;
    do_reset();
    overflow = 1'b1;
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    checks++; if (obs_level !== 3'd3) begin errors++; $display("FAIL midrst_pre_level: got %0d expected 3", obs_level); end
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    overflow = 1'b0;
    #1;
    checks++; if (obs_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", obs_level); end
    checks++; if (obs_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %b expected 0", obs_wr_en); end
    checks++; if (obs_data_w !== 8'h00) begin errors++; $display("FAIL midrst_data_w: got %02h expected 00", obs_data_w); end
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", obs_in_ready); end
    exp_q.delete();
    @(negedge clk_w);
    reset_n = 1'b1;
    @(posedge clk_w);
    #1;
    clear_stats();
    mon_en = 1'b1;
    push_word(8'h5A);
    checks++;
    if (obs_wr_en !== 1'b1 || obs_data_w !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_restart: got wr_en=%b data_w=%02h expected wr_en=1 data_w=5a", obs_wr_en, obs_data_w);
    end
    idle(3);
    checks++; if (wr_seen !== 1) begin errors++; $display("FAIL midrst_write_count: got %0d expected 1", wr_seen); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_stall_fill();
    test_drop_on_overflow();
    test_drop_all();
    test_saturation();
    test_reset_mid_burst();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
